// File: rtl/cla_pkg.sv
// Shared constants and types for the 16-bit lookahead/ripple adder.
package cla_pkg;
  localparam int DATA_W  = 16;
  localparam int BLK_W   = 4;
  localparam int NUM_BLK = 4;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [BLK_W-1:0]  nib_t;
endpackage

// File: rtl/cla_4bit.sv
// Combinational 4-bit carry-lookahead block. All carries are flat
// sum-of-products on cin so nothing ripples inside the block.
// c_msb is the carry into bit 3, used for signed overflow detection.
module cla_4bit
  import cla_pkg::*;
(
  input  logic [BLK_W-1:0] a,
  input  logic [BLK_W-1:0] b,
  input  logic             cin,
  output logic [BLK_W-1:0] s,
  output logic             cout,
  output logic             c_msb
);
  nib_t                p, g;
  logic [BLK_W:0]      c;

  // propagate/generate, lookahead carries and sum bits
  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
    s     = p ^ c[BLK_W-1:0];
    cout  = c[4];
    c_msb = c[3];
  end
endmodule

// File: rtl/cla16_ripple_adder.sv
// Registered 16-bit adder: four 4-bit CLA blocks with block-to-block carry
// ripple. REG_IN=1 adds an input register stage (latency 2, else 1).
// Macro CLA16_OVERFLOW_EN adds the registered signed-overflow output ovf.
module cla16_ripple_adder
  import cla_pkg::*;
#(
  parameter int REG_IN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic              c_in,
  output logic [DATA_W-1:0] sum,
`ifdef CLA16_OVERFLOW_EN
  output logic              ovf,
`endif
  output logic              c_out
);
  word_t                             op_a, op_b;
  logic                              op_c;
  logic [NUM_BLK-1:0][BLK_W-1:0]     sum_nib;
  logic [NUM_BLK:0]                  carry;
  logic [NUM_BLK-1:0]                c_msb;

  generate
    if (REG_IN != 0) begin : g_reg_in
      word_t in1_q, in1_d, in2_q, in2_d;
      logic  c_in_q, c_in_d;

      // next-state of the optional operand register
      always_comb begin
        in1_d  = in1;
        in2_d  = in2;
        c_in_d = c_in;
      end

      // operand register, cleared by reset
      always_ff @(posedge clk) begin
        if (rst) begin
          in1_q  <= '0;
          in2_q  <= '0;
          c_in_q <= 1'b0;
        end else begin
          in1_q  <= in1_d;
          in2_q  <= in2_d;
          c_in_q <= c_in_d;
        end
      end

      assign op_a = in1_q;
      assign op_b = in2_q;
      assign op_c = c_in_q;
    end else begin : g_no_reg_in
      assign op_a = in1;
      assign op_b = in2;
      assign op_c = c_in;
    end
  endgenerate

  assign carry[0] = op_c;

  generate
    for (genvar k = 0; k < NUM_BLK; k++) begin : g_blk
      cla_4bit u_cla (
        .a     (op_a[k*BLK_W +: BLK_W]),
        .b     (op_b[k*BLK_W +: BLK_W]),
        .cin   (carry[k]),
        .s     (sum_nib[k]),
        .cout  (carry[k+1]),
        .c_msb (c_msb[k])
      );
    end
  endgenerate

  // Only block 3's c_msb matters, and only when overflow is enabled.
  logic unused_c_msb;
  assign unused_c_msb = ^c_msb;

  word_t sum_q, sum_d;
  logic  c_out_q, c_out_d;

  // next result from the adder chain
  always_comb begin
    sum_d   = sum_nib;
    c_out_d = carry[NUM_BLK];
  end

  // result register; reset wins over capture
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;

`ifdef CLA16_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // signed overflow: carry into bit 15 differs from carry out of bit 15
  always_comb begin
    ovf_d = c_msb[NUM_BLK-1] ^ carry[NUM_BLK];
  end

  // overflow register, same latency as sum
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_cla16_ripple_adder.sv
// Directed bench for cla16_ripple_adder: one instance with REG_IN=0 and one
// with REG_IN=1 share inputs; each is checked at its own latency.
module tb_cla16_ripple_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in1, in2;
  logic        c_in;
  logic [15:0] sum0, sum1;
  logic        cout0, cout1;
`ifdef CLA16_OVERFLOW_EN
  logic        ovf0, ovf1;
`endif

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  cla16_ripple_adder #(.REG_IN(0)) dut0 (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .c_in(c_in),
    .sum(sum0),
`ifdef CLA16_OVERFLOW_EN
    .ovf(ovf0),
`endif
    .c_out(cout0)
  );

  cla16_ripple_adder #(.REG_IN(1)) dut1 (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .c_in(c_in),
    .sum(sum1),
`ifdef CLA16_OVERFLOW_EN
    .ovf(ovf1),
`endif
    .c_out(cout1)
  );

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; in1 = 16'h1234; in2 = 16'h4321; c_in = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    nvec++;
    if ({cout0, sum0} !== 17'h0) begin
      nmis++; $display("FAIL reset_lat1 got c=%b s=%h want c=0 s=0000", cout0, sum0);
    end
    if ({cout1, sum1} !== 17'h0) begin
      nmis++; $display("FAIL reset_lat2 got c=%b s=%h want c=0 s=0000", cout1, sum1);
    end
`ifdef CLA16_OVERFLOW_EN
    if ({ovf0, ovf1} !== 2'b00) begin
      nmis++; $display("FAIL reset_ovf got %b%b want 00", ovf0, ovf1);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Each vector held for two edges: latency-1 check after the first,
  // latency-2 check after the second.
  task automatic test_arith;
    logic [15:0] a [6]  = '{16'd16285, 16'd3745,  16'd40000, 16'd25535, 16'hFFFF, 16'h0000};
    logic [15:0] b [6]  = '{16'd3745,  16'd16285, 16'd25535, 16'd40001, 16'h0000, 16'h0000};
    logic        ci [6] = '{1'b0,      1'b1,      1'b0,      1'b0,      1'b1,     1'b0};
    logic [15:0] es [6] = '{16'd20030, 16'd20031, 16'd65535, 16'd0,     16'h0000, 16'h0000};
    logic        ec [6] = '{1'b0,      1'b0,      1'b0,      1'b1,      1'b1,     1'b0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in1 = a[i]; in2 = b[i]; c_in = ci[i];
      @(posedge clk); #1;
      nvec++;
      if (sum0 !== es[i] || cout0 !== ec[i]) begin
        nmis++; $display("FAIL arith%0d_lat1 got c=%b s=%h want c=%b s=%h", i, cout0, sum0, ec[i], es[i]);
      end
      @(posedge clk); #1;
      if (sum1 !== es[i] || cout1 !== ec[i]) begin
        nmis++; $display("FAIL arith%0d_lat2 got c=%b s=%h want c=%b s=%h", i, cout1, sum1, ec[i], es[i]);
      end
    end
  endtask

`ifdef CLA16_OVERFLOW_EN
  task automatic test_overflow;
    logic [15:0] a [3]  = '{16'h7FFF, 16'h8000, 16'd40000};
    logic [15:0] b [3]  = '{16'h0001, 16'h8000, 16'd25535};
    logic [15:0] es [3] = '{16'h8000, 16'h0000, 16'hFFFF};
    logic        ec [3] = '{1'b0,     1'b1,     1'b0};
    logic        eo [3] = '{1'b1,     1'b1,     1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in1 = a[i]; in2 = b[i]; c_in = 1'b0;
      @(posedge clk); #1;
      nvec++;
      if (sum0 !== es[i] || cout0 !== ec[i] || ovf0 !== eo[i]) begin
        nmis++; $display("FAIL ovf%0d_lat1 got c=%b s=%h o=%b want c=%b s=%h o=%b",
                         i, cout0, sum0, ovf0, ec[i], es[i], eo[i]);
      end
      @(posedge clk); #1;
      if (sum1 !== es[i] || cout1 !== ec[i] || ovf1 !== eo[i]) begin
        nmis++; $display("FAIL ovf%0d_lat2 got c=%b s=%h o=%b want c=%b s=%h o=%b",
                         i, cout1, sum1, ovf1, ec[i], es[i], eo[i]);
      end
    end
  endtask
`endif

  // Reset must override a live max-value add; after release the latency-1
  // copy shows the result one edge later, the latency-2 copy one more.
  task automatic test_reset_priority;
    @(negedge clk);
    rst = 1'b1; in1 = 16'hFFFF; in2 = 16'hFFFF; c_in = 1'b1;
    @(posedge clk); #1;
    nvec++;
    if ({cout0, sum0} !== 17'h0 || {cout1, sum1} !== 17'h0) begin
      nmis++; $display("FAIL rstprio_hold got %b/%h %b/%h want 0/0000 0/0000", cout0, sum0, cout1, sum1);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    nvec++;
    if (sum0 !== 16'hFFFF || cout0 !== 1'b1) begin
      nmis++; $display("FAIL rstprio_lat1 got c=%b s=%h want c=1 s=ffff", cout0, sum0);
    end
    if (sum1 !== 16'h0000 || cout1 !== 1'b0) begin
      nmis++; $display("FAIL rstprio_lat2_early got c=%b s=%h want c=0 s=0000", cout1, sum1);
    end
    @(posedge clk); #1;
    if (sum1 !== 16'hFFFF || cout1 !== 1'b1) begin
      nmis++; $display("FAIL rstprio_lat2 got c=%b s=%h want c=1 s=ffff", cout1, sum1);
    end
  endtask

  // New operands every cycle; both pipelines must keep up.
  task automatic test_back_to_back;
    logic [15:0] a [4]  = '{16'h0001, 16'h00FF, 16'h0F0F, 16'hABCD};
    logic [15:0] b [4]  = '{16'h0001, 16'h0001, 16'hF0F0, 16'h5433};
    logic        ci [4] = '{1'b0,     1'b0,     1'b1,     1'b0};
    logic [15:0] es [4] = '{16'h0002, 16'h0100, 16'h0000, 16'h0000};
    logic        ec [4] = '{1'b0,     1'b0,     1'b1,     1'b1};
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i < 4) begin
        in1 = a[i]; in2 = b[i]; c_in = ci[i];
      end
      @(posedge clk); #1;
      if (i < 4) begin
        nvec++;
        if (sum0 !== es[i] || cout0 !== ec[i]) begin
          nmis++; $display("FAIL b2b%0d_lat1 got c=%b s=%h want c=%b s=%h", i, cout0, sum0, ec[i], es[i]);
        end
      end
      if (i > 0) begin
        if (sum1 !== es[i-1] || cout1 !== ec[i-1]) begin
          nmis++; $display("FAIL b2b%0d_lat2 got c=%b s=%h want c=%b s=%h", i-1, cout1, sum1, ec[i-1], es[i-1]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in1 = '0; in2 = '0; c_in = 1'b0;
    test_reset();
    test_arith();
`ifdef CLA16_OVERFLOW_EN
    test_overflow();
`endif
    test_reset_priority();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
